adc_serial_readout: RTL and testbench
=====================================

# adc_serial_readout

Parametrised multi-channel serial ADC readout engine for the kc705 readout firmware, successor to the fixed 16-channel CNV/SCK/SDO capture path. Generates the ADC conversion strobe and serial clock, deserialises all SDO lanes in parallel, and streams one word per channel over a valid/ready interface toward the PCIe FIFO. Supports both free-running conversion and TLU-triggered single-frame mode, with BUSY back to the TLU and overflow/missed-trigger accounting.

## Interface
- N_CH, 16, number of SDO lanes (1..32)
- SAMPLE_W, 16, bits per conversion, MSB first (4..24)
- CNV_CYCLES, 4, clk cycles cnv is held high
- SCK_HALF, 2, clk cycles per sck half-period (>=1)
- PERIOD, 200, free-run frame period in clk cycles; must be >= CNV_CYCLES + 2*SCK_HALF*SAMPLE_W + N_CH + 2
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level; enables acquisition
- trig_mode  in  1  0 = free-run, 1 = one frame per trigger (sampled only in IDLE)
- trigger  in  1  synchronous single-cycle trigger pulse
- busy  out  1  TLU busy
- cnv  out  1  conversion strobe
- sck  out  1  ADC serial clock
- sdo  in  N_CH  serial data lanes, already synchronised to clk
- data_out  out  SAMPLE_W  sample word
- ch_id  out  $clog2(N_CH)  lane index of data_out
- data_valid  out  1  word valid
- data_ready  in  1  consumer accepts word
- frame_cnt  out  16  completed frames, wraps 0xFFFF->0
- missed_trig  out  8  triggers ignored while busy, saturates at 0xFF
- overflow  out  1  sticky: free-run period expired before frame drained
- clr  in  1  synchronous clear of overflow and missed_trig

## Operation
- FSM: IDLE -> CONV -> SHIFT -> OUT -> WAIT -> (CONV | IDLE).
- IDLE: free-run with start=1 -> CONV next cycle, period counter loads PERIOD-1. Trigger mode with start=1 and trigger=1 -> CONV next cycle, busy=1.
- CONV: cnv=1 for exactly CNV_CYCLES cycles, sck=0.
- SHIFT: SAMPLE_W sck pulses; each pulse is SCK_HALF cycles low then SCK_HALF cycles high. All N_CH shift registers capture sdo on the clk edge that ends each high phase (sck 1->0). Duration exactly 2*SCK_HALF*SAMPLE_W cycles; sck=0 on exit.
- OUT: words presented lane 0 first, ch_id ascending; a word advances only on data_valid & data_ready. data_out/ch_id stable while valid & !ready. Last handshake increments frame_cnt.
- WAIT: free-run: wait for period counter to reach 0, then CONV if start=1 else IDLE. Trigger mode: busy drops, -> IDLE.
- Period counter free-runs from frame start; if it reaches 0 while in CONV/SHIFT/OUT, that period is skipped (no new conversion), overflow set; counter reloads and current frame continues.
- trigger while busy=1, or in free-run mode: ignored; missed_trig increments (trigger mode only). clr and increment in same cycle: clr wins.
- start deasserted mid-frame: current frame completes through OUT, then IDLE.
- trig_mode changes outside IDLE take effect at next IDLE.

## Timing
- Reset values: cnv=0, sck=0, busy=0, data_valid=0, data_out=0, ch_id=0, frame_cnt=0, missed_trig=0, overflow=0, FSM=IDLE. All outputs registered.
- Reset mid-operation: all state cleared asynchronously; partial frame discarded; no words emitted after release until a new start/trigger.
- start/trigger -> cnv rising: 1 cycle.
- cnv falling -> first sck rising: SCK_HALF cycles.
- Last sck falling -> first data_valid: 1 cycle.
- With data_ready=1: N_CH consecutive valid cycles, one word each.
- busy: rises cycle after accepted trigger, falls cycle after last OUT handshake.
- Defaults: frame = 4 + 64 + 16 = 84 cycles of activity per 200-cycle period.

## Test plan
- Free-run, defaults, sdo[k] drives 16-bit pattern 0xA500+k MSB first, ready=1 -> 16 words 0xA500..0xA50F, ch_id 0..15, cnv every 200 cycles, frame_cnt increments per frame.
- Trigger mode, single trigger pulse -> busy 1 cycle later, one frame of 16 words, busy falls after word 15, no further cnv without trigger.
- Trigger mode, 3 extra triggers during busy -> missed_trig=3, only one frame; clr -> missed_trig=0.
- Free-run, data_ready held 0 for 300 cycles -> overflow=1, one period skipped (no cnv), data_out held stable, words resume intact on ready.
- start deasserted during SHIFT -> frame completes all 16 words, then IDLE, cnv stays 0.
- rst_n pulsed low during SHIFT -> all outputs at reset values immediately; after release with start=1, next frame data correct and frame_cnt restarts from 1.

Source files
------------

// File: rtl/adc_serial_readout_if.sv
// Word stream from the ADC readout engine toward the PCIe FIFO.
// The engine drives the master side; the consumer drives data_ready.
interface adc_serial_readout_if #(
  parameter int N_CH     = 16,
  parameter int SAMPLE_W = 16
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [SAMPLE_W-1:0] data_out;
  logic [CH_W-1:0]     ch_id;
  logic                data_valid;
  logic                data_ready;

  modport master (output data_out, output ch_id, output data_valid, input data_ready);
  modport slave  (input data_out, input ch_id, input data_valid, output data_ready);
endinterface

// File: rtl/adc_serial_readout.sv
// Multi-lane serial ADC readout: CNV/SCK generation, parallel SDO
// deserialisation, per-channel word streaming, free-run or TLU-triggered.
module adc_serial_readout #(
  parameter int N_CH       = 16,
  parameter int SAMPLE_W   = 16,
  parameter int CNV_CYCLES = 4,
  parameter int SCK_HALF   = 2,
  parameter int PERIOD     = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              trig_mode,
  input  logic              trigger,
  input  logic              clr,
  output logic              busy,
  output logic              cnv,
  output logic              sck,
  input  logic [N_CH-1:0]   sdo,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        missed_trig,
  output logic              overflow,
  adc_serial_readout_if.master rd
);

  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_MAX = (CNV_CYCLES > 2*SCK_HALF) ? CNV_CYCLES : 2*SCK_HALF;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(SAMPLE_W + 1);
  localparam int PER_W   = $clog2(PERIOD + 1);

  typedef enum logic [2:0] {IDLE, CONV, SHIFT, OUT, WAIT} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [PER_W-1:0]    period_q, period_d;
  logic                mode_q, mode_d;
  logic                busy_q, busy_d;
  logic                cnv_q, cnv_d;
  logic                sck_q, sck_d;
  logic                valid_q, valid_d;
  logic                overflow_q, overflow_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic [15:0]         frame_q, frame_d;
  logic [7:0]          missed_q, missed_d;
  logic [SAMPLE_W-1:0] shreg_q [N_CH];
  logic [SAMPLE_W-1:0] shreg_d [N_CH];
  logic                capture;
  logic                period_zero;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    ch_d        = ch_q;
    mode_d      = mode_q;
    busy_d      = busy_q;
    valid_d     = valid_q;
    data_d      = data_q;
    frame_d     = frame_q;
    overflow_d  = overflow_q;
    missed_d    = missed_q;
    capture     = 1'b0;
    period_zero = (period_q == '0);
    period_d    = period_zero ? PER_W'(PERIOD - 1) : period_q - 1'b1;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        ch_d  = '0;
        if (start && !trig_mode) begin
          state_d  = CONV;
          mode_d   = 1'b0;
          period_d = PER_W'(PERIOD - 1);
        end else if (start && trig_mode && trigger) begin
          state_d = CONV;
          mode_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      CONV: begin
        if (cnt_q == CNT_W'(CNV_CYCLES - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        // Last cycle of each high phase: sck falls on this edge and lanes are sampled.
        if (cnt_q == CNT_W'(2*SCK_HALF - 1)) begin
          capture = 1'b1;
          cnt_d   = '0;
          if (bit_q == BIT_W'(SAMPLE_W - 1)) begin
            state_d = OUT;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OUT: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          ch_d    = '0;
          data_d  = shreg_q[0];
        end else if (rd.data_ready) begin
          if (ch_q == CH_W'(N_CH - 1)) begin
            valid_d = 1'b0;
            state_d = WAIT;
            frame_d = frame_q + 16'd1;
            busy_d  = 1'b0;
          end else begin
            ch_d   = ch_q + 1'b1;
            data_d = shreg_q[ch_d];
          end
        end
      end
      WAIT: begin
        if (mode_q || !start) begin
          state_d = IDLE;
        end else if (period_zero) begin
          state_d = CONV;
        end
      end
      default: state_d = IDLE;
    endcase

    // A period boundary that lands inside an active frame is dropped, not queued.
    if (!mode_q && period_zero && (state_q inside {CONV, SHIFT, OUT})) begin
      overflow_d = 1'b1;
    end
    if (clr) begin
      overflow_d = 1'b0;
      missed_d   = '0;
    end else if (trigger && busy_q && (missed_q != 8'hFF)) begin
      missed_d = missed_q + 8'd1;
    end

    cnv_d = (state_d == CONV);
    sck_d = (state_d == SHIFT) && (cnt_d >= CNT_W'(SCK_HALF));
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      shreg_d[k] = capture ? {shreg_q[k][SAMPLE_W-2:0], sdo[k]} : shreg_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      ch_q       <= '0;
      period_q   <= '0;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      cnv_q      <= 1'b0;
      sck_q      <= 1'b0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      data_q     <= '0;
      frame_q    <= '0;
      missed_q   <= '0;
      for (int k = 0; k < N_CH; k++) shreg_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      ch_q       <= ch_d;
      period_q   <= period_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      cnv_q      <= cnv_d;
      sck_q      <= sck_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      data_q     <= data_d;
      frame_q    <= frame_d;
      missed_q   <= missed_d;
      for (int k = 0; k < N_CH; k++) shreg_q[k] <= shreg_d[k];
    end
  end

  assign busy          = busy_q;
  assign cnv           = cnv_q;
  assign sck           = sck_q;
  assign frame_cnt     = frame_q;
  assign missed_trig   = missed_q;
  assign overflow      = overflow_q;
  assign rd.data_out   = data_q;
  assign rd.ch_id      = ch_q;
  assign rd.data_valid = valid_q;

endmodule

// File: tb/tb_adc_serial_readout.sv
// Directed bench for adc_serial_readout with a behavioural 16-lane ADC
// that shifts a per-lane word (pat_base + lane) out MSB first.
module tb_adc_serial_readout;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        trig_mode;
  logic        trigger;
  logic        clr;
  logic        busy;
  logic        cnv;
  logic        sck;
  logic [15:0] sdo;
  logic [15:0] frame_cnt;
  logic [7:0]  missed_trig;
  logic        overflow;

  adc_serial_readout_if #(.N_CH(16), .SAMPLE_W(16)) rd_if ();

  adc_serial_readout dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .trig_mode   (trig_mode),
    .trigger     (trigger),
    .clr         (clr),
    .busy        (busy),
    .cnv         (cnv),
    .sck         (sck),
    .sdo         (sdo),
    .frame_cnt   (frame_cnt),
    .missed_trig (missed_trig),
    .overflow    (overflow),
    .rd          (rd_if)
  );

  int checks;
  int failures;
  int cyc;
  int cnv_rises;
  int cnv_high;
  int sck_rises;
  int last_rise;
  int prev_rise;
  int bit_idx;
  logic cnv_prev;
  logic sck_prev;
  logic [15:0] pat_base;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // ADC model and edge monitor; runs at negedge so DUT outputs are settled
  always @(negedge clk) begin
    logic [15:0] word;
    if (cnv) bit_idx = 0;
    else if (sck_prev && !sck) bit_idx = bit_idx + 1;
    if (cnv && !cnv_prev) begin
      cnv_rises = cnv_rises + 1;
      prev_rise = last_rise;
      last_rise = cyc;
    end
    if (cnv) cnv_high = cnv_high + 1;
    if (sck && !sck_prev) sck_rises = sck_rises + 1;
    cnv_prev = cnv;
    sck_prev = sck;
    for (int k = 0; k < 16; k++) begin
      word   = pat_base + 16'(k);
      sdo[k] = (bit_idx < 16) ? word[15 - bit_idx] : 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic tm, input logic rdy);
    start              = s;
    trig_mode          = tm;
    rd_if.data_ready   = rdy;
  endtask

  task automatic pulseTrigger();
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic waitValid(input int limit, output int n);
    n = 0;
    while (!rd_if.data_valid && n < limit) begin
      @(negedge clk);
      n = n + 1;
    end
  endtask

  task automatic waitCnvRise(input int limit, output bit seen, output int gap);
    int n0;
    int c;
    n0 = cnv_rises;
    c  = 0;
    while (cnv_rises == n0 && c < limit) begin
      @(negedge clk);
      c = c + 1;
    end
    seen = (cnv_rises != n0);
    gap  = last_rise - prev_rise;
  endtask

  // Accepts one frame; a handshake is pending whenever valid & ready at a negedge
  task automatic collectFrame(input string tag, input logic [15:0] base);
    int idx;
    int c;
    int first;
    idx   = 0;
    c     = 0;
    first = -1;
    while (c < 600 && idx < 16) begin
      if (rd_if.data_valid && rd_if.data_ready) begin
        if (first < 0) first = c;
        checkOutput({tag, "_data"}, 32'(rd_if.data_out), 32'(base + 16'(idx)));
        checkOutput({tag, "_ch_id"}, 32'(rd_if.ch_id), 32'(idx));
        idx = idx + 1;
      end
      if (idx < 16) begin
        @(negedge clk);
        c = c + 1;
      end
    end
    checkOutput({tag, "_words"}, 32'(idx), 32'd16);
    checkOutput({tag, "_burst_len"}, 32'(c - first + 1), 32'd16);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int h0;
    int s0;
    int r0;
    int gap;
    bit seen;

    checks    = 0;
    failures  = 0;
    cyc       = 0;
    cnv_rises = 0;
    cnv_high  = 0;
    sck_rises = 0;
    last_rise = 0;
    prev_rise = 0;
    bit_idx   = 0;
    cnv_prev  = 1'b0;
    sck_prev  = 1'b0;
    pat_base  = 16'hA500;
    rst_n     = 1'b0;
    trigger   = 1'b0;
    clr       = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    checkOutput("rst_cnv", 32'(cnv), 32'd0);
    checkOutput("rst_sck", 32'(sck), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(rd_if.data_valid), 32'd0);
    checkOutput("rst_data", 32'(rd_if.data_out), 32'd0);
    checkOutput("rst_ch_id", 32'(rd_if.ch_id), 32'd0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("rst_missed", 32'(missed_trig), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_no_cnv", 32'(cnv_rises), 32'd0);

    // Free-run frame 1: latency, pulse widths, data
    h0 = cnv_high;
    s0 = sck_rises;
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("cnv_before_edge", 32'(cnv), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("start_to_cnv", 32'(cnv), 32'd1);
    waitValid(200, n);
    checkOutput("first_valid_latency", 32'(n), 32'd70);
    checkOutput("freerun_busy", 32'(busy), 32'd0);
    collectFrame("f1", 16'hA500);
    @(negedge clk);
    checkOutput("f1_frame_cnt", 32'(frame_cnt), 32'd1);
    checkOutput("f1_cnv_width", 32'(cnv_high - h0), 32'd4);
    checkOutput("f1_sck_pulses", 32'(sck_rises - s0), 32'd16);

    // Free-run frame 2: 200-cycle period
    waitCnvRise(300, seen, gap);
    checkOutput("f2_cnv_seen", 32'(seen), 32'd1);
    checkOutput("f2_period", 32'(gap), 32'd200);
    pat_base = 16'h5A00;
    collectFrame("f2", 16'h5A00);
    @(negedge clk);
    checkOutput("f2_frame_cnt", 32'(frame_cnt), 32'd2);

    // Frame 3: start dropped during SHIFT, frame still completes
    waitCnvRise(300, seen, gap);
    checkOutput("f3_cnv_seen", 32'(seen), 32'd1);
    pat_base = 16'h0F00;
    repeat (10) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1);
    collectFrame("f3", 16'h0F00);
    @(negedge clk);
    checkOutput("f3_frame_cnt", 32'(frame_cnt), 32'd3);
    r0 = cnv_rises;
    repeat (250) @(negedge clk);
    checkOutput("stop_no_cnv", 32'(cnv_rises - r0), 32'd0);
    checkOutput("stop_cnv_low", 32'(cnv), 32'd0);

    // Trigger mode: one frame per trigger, extra triggers counted
    pat_base = 16'h1200;
    applyStimulus(1'b1, 1'b1, 1'b1);
    r0 = cnv_rises;
    repeat (5) @(negedge clk);
    checkOutput("trig_wait_no_cnv", 32'(cnv_rises - r0), 32'd0);
    checkOutput("busy_before_trig", 32'(busy), 32'd0);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    checkOutput("trig_busy", 32'(busy), 32'd1);
    checkOutput("trig_cnv", 32'(cnv), 32'd1);
    repeat (3) pulseTrigger();
    collectFrame("trig", 16'h1200);
    checkOutput("busy_at_last_word", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("busy_after_frame", 32'(busy), 32'd0);
    checkOutput("trig_frame_cnt", 32'(frame_cnt), 32'd4);
    checkOutput("missed_trig", 32'(missed_trig), 32'd3);
    repeat (300) @(negedge clk);
    checkOutput("trig_single_frame", 32'(cnv_rises - r0), 32'd1);
    pulseClear();
    checkOutput("missed_clr", 32'(missed_trig), 32'd0);

    // Free-run with consumer stalled past one period
    pat_base = 16'h7700;
    r0 = cnv_rises;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitValid(200, n);
    checkOutput("stall_first_valid", 32'(n), 32'd70);
    checkOutput("stall_data_start", 32'(rd_if.data_out), 32'h7700);
    repeat (300) @(negedge clk);
    checkOutput("stall_data_hold", 32'(rd_if.data_out), 32'h7700);
    checkOutput("stall_ch_hold", 32'(rd_if.ch_id), 32'd0);
    checkOutput("stall_valid_hold", 32'(rd_if.data_valid), 32'd1);
    checkOutput("overflow_set", 32'(overflow), 32'd1);
    checkOutput("period_skipped", 32'(cnv_rises - r0), 32'd1);
    rd_if.data_ready = 1'b1;
    collectFrame("stall", 16'h7700);
    @(negedge clk);
    checkOutput("overflow_sticky", 32'(overflow), 32'd1);
    pulseClear();
    checkOutput("overflow_clr", 32'(overflow), 32'd0);
    waitCnvRise(100, seen, gap);
    checkOutput("resume_cnv_seen", 32'(seen), 32'd1);
    checkOutput("resume_gap", 32'(gap), 32'd400);

    // Asynchronous reset during SHIFT
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_cnv", 32'(cnv), 32'd0);
    checkOutput("arst_sck", 32'(sck), 32'd0);
    checkOutput("arst_valid", 32'(rd_if.data_valid), 32'd0);
    checkOutput("arst_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    pat_base = 16'hC3A0;
    @(negedge clk);
    rst_n = 1'b1;
    waitValid(200, n);
    checkOutput("post_rst_latency", 32'(n), 32'd70);
    collectFrame("post_rst", 16'hC3A0);
    @(negedge clk);
    checkOutput("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
